// File: rtl/ipv4_rx_filter.sv
// ipv4_rx_filter: IPv4 header check, address/protocol filter, option skip, padding strip
// and per-frame metadata between the Ethernet MAC byte stream and the transport parser.
module ipv4_rx_filter #(
  parameter int NUM_ADDRS = 4,
  parameter logic [32*NUM_ADDRS-1:0] ADDR_TABLE = {NUM_ADDRS{32'h0}},
  parameter logic [7:0] PROTO_A = 8'd17,
  parameter logic [7:0] PROTO_B = 8'd17,
  localparam int IW = NUM_ADDRS > 1 ? $clog2(NUM_ADDRS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    eth_data_in,
  input  logic          eth_byte_valid,
  input  logic          eth_eof,
  input  logic          eth_err,
  output logic [7:0]    ip_data_out,
  output logic          ip_byte_valid,
  output logic          ip_eof,
  output logic          ip_err,
  output logic          meta_valid,
  output logic [31:0]   meta_src_addr,
  output logic [7:0]    meta_proto,
  output logic [IW-1:0] meta_match_idx,
  output logic [15:0]   meta_payload_len
);
  typedef enum logic [1:0] {S_HDR, S_PAY, S_PAD, S_FLUSH} state_t;
  state_t        r_state;
  logic [5:0]    r_cnt;
  logic [3:0]    r_ihl;
  logic [15:0]   r_tl;
  logic [15:0]   r_rem;
  logic [15:0]   r_csum;
  logic [7:0]    r_hi;
  logic [7:0]    r_proto;
  logic [31:0]   r_src;
  logic [23:0]   r_dst;
  logic [IW-1:0] r_idx;
  logic [5:0]    w_last;
  logic [15:0]   w_hlen;
  logic [15:0]   w_tl;
  logic [15:0]   w_plen;
  logic [16:0]   w_sum;
  logic [15:0]   w_fold;
  logic [31:0]   w_dst;
  logic          w_hit;
  logic [IW-1:0] w_idx;
  logic          w_bad;
  logic          w_pass;
  always_comb begin
    w_hlen = {10'd0, r_ihl, 2'b00};
    w_last = {r_ihl, 2'b00} - 6'd1;
    w_tl   = {r_tl[15:8], eth_data_in};
    w_plen = r_tl - w_hlen;
    w_dst  = {r_dst, eth_data_in};
    w_sum  = {1'b0, r_csum} + {1'b0, r_hi, eth_data_in};
    w_fold = w_sum[15:0] + {15'd0, w_sum[16]};
    w_hit  = 1'b0;
    w_idx  = '0;
    for (int i = NUM_ADDRS - 1; i >= 0; i--)
      if (ADDR_TABLE[32*i +: 32] == w_dst) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    w_bad  = (r_cnt == 6'd0 && (eth_data_in[7:4] != 4'd4 || eth_data_in[3:0] < 4'd5)) ||
             (r_cnt == 6'd3 && w_tl < w_hlen) ||
             (r_cnt == 6'd9 && eth_data_in != PROTO_A && eth_data_in != PROTO_B) ||
             (r_cnt == 6'd19 && !w_hit) ||
             (r_cnt == w_last && w_fold != 16'hFFFF);
    w_pass = r_cnt == w_last && !w_bad;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_HDR;
      r_cnt            <= '0;
      r_ihl            <= '0;
      r_tl             <= '0;
      r_rem            <= '0;
      r_csum           <= '0;
      r_hi             <= '0;
      r_proto          <= '0;
      r_src            <= '0;
      r_dst            <= '0;
      r_idx            <= '0;
      ip_data_out      <= '0;
      ip_byte_valid    <= 1'b0;
      ip_eof           <= 1'b0;
      ip_err           <= 1'b0;
      meta_valid       <= 1'b0;
      meta_src_addr    <= '0;
      meta_proto       <= '0;
      meta_match_idx   <= '0;
      meta_payload_len <= '0;
    end else begin
      ip_byte_valid <= 1'b0;
      ip_eof        <= 1'b0;
      ip_err        <= 1'b0;
      meta_valid    <= 1'b0;
      if (eth_byte_valid) begin
        case (r_state)
          S_HDR: begin
            r_cnt <= r_cnt + 6'd1;
            // even bytes hold the high half of the next checksum word
            if (r_cnt[0]) r_csum <= w_fold;
            else r_hi <= eth_data_in;
            if (r_cnt == 6'd0) r_ihl <= eth_data_in[3:0];
            if (r_cnt == 6'd2) r_tl[15:8] <= eth_data_in;
            if (r_cnt == 6'd3) r_tl[7:0] <= eth_data_in;
            if (r_cnt == 6'd9) r_proto <= eth_data_in;
            if (r_cnt >= 6'd12 && r_cnt <= 6'd15) r_src <= {r_src[23:0], eth_data_in};
            if (r_cnt >= 6'd16 && r_cnt <= 6'd19) r_dst <= w_dst[23:0];
            if (r_cnt == 6'd19) r_idx <= w_idx;
            if (w_bad || w_pass || eth_eof) begin
              r_cnt  <= '0;
              r_csum <= '0;
            end
            if (w_bad) begin
              ip_err  <= 1'b1;
              r_state <= eth_eof ? S_HDR : S_FLUSH;
            end else if (w_pass) begin
              meta_valid       <= 1'b1;
              meta_src_addr    <= r_src;
              meta_proto       <= r_proto;
              meta_match_idx   <= r_cnt == 6'd19 ? w_idx : r_idx;
              meta_payload_len <= w_plen;
              r_rem            <= w_plen;
              // frame ending on the last header byte is short unless it carries no payload
              if (eth_eof) begin
                ip_eof <= 1'b1;
                ip_err <= eth_err || w_plen != 16'd0;
              end else
                r_state <= w_plen == 16'd0 ? S_PAD : S_PAY;
            end else if (eth_eof)
              ip_err <= 1'b1;
          end
          S_PAY: begin
            ip_byte_valid <= 1'b1;
            ip_data_out   <= eth_data_in;
            r_rem         <= r_rem - 16'd1;
            if (eth_eof) begin
              ip_eof  <= 1'b1;
              ip_err  <= eth_err || r_rem > 16'd1;
              r_state <= S_HDR;
            end else if (r_rem == 16'd1)
              r_state <= S_PAD;
          end
          S_PAD: if (eth_eof) begin
            ip_eof  <= 1'b1;
            ip_err  <= eth_err;
            r_state <= S_HDR;
          end
          default: if (eth_eof) r_state <= S_HDR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ipv4_rx_filter.sv
// tb_ipv4_rx_filter: frame-level reference model feeds a timestamped scoreboard of expected output events.
module tb_ipv4_rx_filter;
  localparam logic [31:0] A0 = 32'h0A00_0001;
  localparam logic [31:0] A1 = 32'h0A00_0002;
  localparam logic [31:0] A2 = 32'hC0A8_0064;
  localparam logic [31:0] A3 = 32'hC0A8_0064;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  eth_data_in = '0;
  logic        eth_byte_valid = 1'b0;
  logic        eth_eof = 1'b0;
  logic        eth_err = 1'b0;
  logic [7:0]  ip_data_out;
  logic        ip_byte_valid, ip_eof, ip_err, meta_valid;
  logic [31:0] meta_src_addr;
  logic [7:0]  meta_proto;
  logic [1:0]  meta_match_idx;
  logic [15:0] meta_payload_len;

  ipv4_rx_filter #(.NUM_ADDRS(4), .ADDR_TABLE({A3, A2, A1, A0}), .PROTO_A(8'd17), .PROTO_B(8'd17)) dut (
    .clk(clk), .rst(rst), .eth_data_in(eth_data_in), .eth_byte_valid(eth_byte_valid),
    .eth_eof(eth_eof), .eth_err(eth_err), .ip_data_out(ip_data_out), .ip_byte_valid(ip_byte_valid),
    .ip_eof(ip_eof), .ip_err(ip_err), .meta_valid(meta_valid), .meta_src_addr(meta_src_addr),
    .meta_proto(meta_proto), .meta_match_idx(meta_match_idx), .meta_payload_len(meta_payload_len)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          bv;
    logic [7:0]  d;
    bit          eof;
    bit          err;
    bit          meta;
    logic [31:0] src;
    logic [7:0]  proto;
    logic [1:0]  idx;
    logic [15:0] plen;
    int          cyc;
  } ev_t;

  ev_t         expq[$];
  ev_t         plan[0:127];
  ev_t         mx;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] tbl[4] = '{A0, A1, A2, A3};

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every output event must match the oldest expected event, including its cycle
  always @(negedge clk) begin
    if (!rst && (ip_byte_valid || ip_eof || ip_err || meta_valid)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d bv=%b eof=%b err=%b meta=%b, required no event",
                 cyc, ip_byte_valid, ip_eof, ip_err, meta_valid);
      end else begin
        mx = expq.pop_front();
        if (cyc !== mx.cyc || ip_byte_valid !== mx.bv || ip_eof !== mx.eof || ip_err !== mx.err ||
            meta_valid !== mx.meta || (mx.bv && ip_data_out !== mx.d) ||
            (mx.meta && (meta_src_addr !== mx.src || meta_proto !== mx.proto ||
                         meta_match_idx !== mx.idx || meta_payload_len !== mx.plen))) begin
          errors++;
          $display("FAIL event got cyc=%0d bv=%b d=%h eof=%b err=%b meta=%b src=%h proto=%0d idx=%0d plen=%0d, required cyc=%0d bv=%b d=%h eof=%b err=%b meta=%b src=%h proto=%0d idx=%0d plen=%0d",
                   cyc, ip_byte_valid, ip_data_out, ip_eof, ip_err, meta_valid, meta_src_addr,
                   meta_proto, meta_match_idx, meta_payload_len, mx.cyc, mx.bv, mx.d, mx.eof,
                   mx.err, mx.meta, mx.src, mx.proto, mx.idx, mx.plen);
        end
      end
    end
  end

  function automatic logic [7:0] at(input bq_t f, input int i);
    return (i < f.size()) ? f[i] : 8'h00;
  endfunction

  function automatic logic [15:0] csum(input bq_t f, input int hl);
    int unsigned s = 0;
    for (int i = 0; i < hl; i += 2) s += {16'd0, at(f, i), at(f, i + 1)};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic bq_t mk(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tl,
                             input logic [7:0] proto, input logic [31:0] dst, input int npay, input int npad);
    bq_t        f;
    logic [15:0] c;
    logic [7:0] h[20];
    int         hl;
    hl = 4 * int'(ihl);
    h = '{{ver, ihl}, 8'h00, tl[15:8], tl[7:0], 8'h12, 8'h34, 8'h40, 8'h00, 8'h40, proto,
          8'h00, 8'h00, 8'hAC, 8'h10, 8'h00, 8'h05, dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
    foreach (h[i]) f.push_back(h[i]);
    for (int i = 20; i < hl; i++) f.push_back(8'($urandom));
    c = ~csum(f, hl);
    f[10] = c[15:8];
    f[11] = c[7:0];
    for (int i = 0; i < npay; i++) f.push_back(8'($urandom));
    for (int i = 0; i < npad; i++) f.push_back(8'h00);
    return f;
  endfunction

  // derive expected per-byte output events straight from the frame contents
  task automatic analyze(input bq_t f, input bit e);
    int          n, ihl, hl, tl, fp, hit, plen;
    logic [7:0]  b0;
    logic [31:0] dst;
    n    = f.size();
    b0   = at(f, 0);
    ihl  = int'(b0[3:0]);
    hl   = 4 * ihl;
    tl   = int'({at(f, 2), at(f, 3)});
    dst  = {at(f, 16), at(f, 17), at(f, 18), at(f, 19)};
    hit  = -1;
    fp   = -1;
    for (int i = 3; i >= 0; i--) if (tbl[i] == dst) hit = i;
    for (int k = 0; k < 128; k++) plan[k] = '{default: '0};
    if (b0[7:4] != 4'd4 || ihl < 5) fp = 0;
    else if (tl < hl) fp = 3;
    else if (at(f, 9) != 8'd17) fp = 9;
    else if (hit < 0) fp = 19;
    else if (csum(f, hl) != 16'hFFFF) fp = hl - 1;
    if (fp >= 0 && fp < n) plan[fp].err = 1'b1;
    else if (n < hl) plan[n-1].err = 1'b1;
    else begin
      plen = tl - hl;
      plan[hl-1].meta  = 1'b1;
      plan[hl-1].src   = {at(f, 12), at(f, 13), at(f, 14), at(f, 15)};
      plan[hl-1].proto = at(f, 9);
      plan[hl-1].idx   = 2'(hit);
      plan[hl-1].plen  = 16'(plen);
      for (int k = hl; k < n && k < hl + plen; k++) begin
        plan[k].bv = 1'b1;
        plan[k].d  = f[k];
      end
      plan[n-1].eof = 1'b1;
      plan[n-1].err = e || (n - 1 < hl + plen - 1);
    end
  endtask

  task automatic send(input bq_t f, input bit e, input int gap, input int stop);
    int  n, m;
    ev_t x;
    n = f.size();
    m = (stop < 0) ? n : stop;
    analyze(f, e);
    for (int k = 0; k < m; k++) begin
      @(negedge clk);
      eth_byte_valid = 1'b1;
      eth_data_in    = f[k];
      eth_eof        = (k == n - 1);
      eth_err        = e && (k == n - 1);
      if (plan[k].bv || plan[k].eof || plan[k].err || plan[k].meta) begin
        x     = plan[k];
        x.cyc = cyc + 1;
        expq.push_back(x);
      end
      for (int g = 0; g < gap && k < m - 1; g++) begin
        @(negedge clk);
        eth_byte_valid = 1'b0;
        eth_eof        = 1'b0;
        eth_err        = 1'b0;
        eth_data_in    = 8'($urandom);
      end
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      eth_byte_valid = 1'b0;
      eth_eof        = 1'b0;
      eth_err        = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    idle(1);
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
    idle(2);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d events outstanding, required 0", nm, expq.size());
      expq.delete();
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({ip_byte_valid, ip_eof, ip_err, meta_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses got %b required 0000", {ip_byte_valid, ip_eof, ip_err, meta_valid});
    end
    checks++;
    if (ip_data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h required 00", ip_data_out);
    end
    checks++;
    if ({meta_src_addr, meta_proto, meta_match_idx, meta_payload_len} !== 58'd0) begin
      errors++;
      $display("FAIL reset_meta got %h required 0", {meta_src_addr, meta_proto, meta_match_idx, meta_payload_len});
    end
    rst = 1'b0;
  endtask

  task automatic test_valid_frame;
    send(mk(4, 5, 28, 17, A2, 8, 0), 1'b0, 0, -1);
    drain("valid_frame");
  endtask

  task automatic test_min_frame;
    send(mk(4, 5, 30, 17, A0, 10, 16), 1'b0, 0, -1);
    drain("min_frame");
  endtask

  task automatic test_options;
    send(mk(4, 6, 30, 17, A1, 6, 2), 1'b0, 1, -1);
    drain("options");
  endtask

  task automatic test_bad_checksum;
    bq_t f;
    f = mk(4, 5, 28, 17, A2, 8, 0);
    f[10] = f[10] ^ 8'h01;
    send(f, 1'b0, 0, -1);
    send(mk(4, 5, 24, 17, A1, 4, 0), 1'b0, 0, -1);
    drain("bad_checksum");
  endtask

  task automatic test_rejects;
    send(mk(6, 5, 28, 17, A2, 8, 0), 1'b0, 0, -1);
    drain("reject_version");
    send(mk(4, 5, 28, 6, A2, 8, 0), 1'b0, 0, -1);
    drain("reject_proto");
    send(mk(4, 5, 28, 17, 32'h0102_0304, 8, 0), 1'b0, 0, -1);
    drain("reject_dst");
    send(mk(4, 5, 16, 17, A2, 0, 8), 1'b0, 0, -1);
    drain("reject_len");
  endtask

  task automatic test_eth_err;
    send(mk(4, 5, 28, 17, A2, 8, 0), 1'b1, 0, -1);
    drain("eth_err");
  endtask

  task automatic test_truncated;
    send(mk(4, 5, 28, 17, A2, 3, 0), 1'b0, 0, -1);
    drain("truncated");
  endtask

  task automatic test_header_eof;
    bq_t f;
    f = mk(4, 5, 28, 17, A2, 8, 0);
    f = f[0:9];
    send(f, 1'b0, 0, -1);
    drain("header_eof");
  endtask

  task automatic test_reset_mid;
    send(mk(4, 5, 28, 17, A2, 8, 0), 1'b0, 0, 24);
    @(negedge clk);
    eth_byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ip_byte_valid, ip_eof, ip_err, meta_valid, ip_data_out} !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h required 0", {ip_byte_valid, ip_eof, ip_err, meta_valid, ip_data_out});
    end
    checks++;
    if ({meta_src_addr, meta_proto, meta_match_idx, meta_payload_len} !== 58'd0) begin
      errors++;
      $display("FAIL reset_mid_meta got %h required 0", {meta_src_addr, meta_proto, meta_match_idx, meta_payload_len});
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending got %0d required 0", expq.size());
      expq.delete();
    end
    @(negedge clk);
    rst = 1'b0;
    send(mk(4, 5, 26, 17, A3, 6, 0), 1'b0, 0, -1);
    drain("after_reset");
  endtask

  task automatic test_back_to_back;
    int ihl, plen;
    send(mk(4, 5, 20, 17, 32'h0102_0304, 0, 0), 1'b0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      ihl  = 5 + (i % 2);
      plen = $urandom_range(0, 5);
      send(mk(4, 4'(ihl), 16'(4 * ihl + plen), 17, tbl[i], plen, $urandom_range(0, 3)), i == 2, 0, -1);
    end
    send(mk(4, 5, 20, 17, A0, 0, 0), 1'b0, 0, -1);
    drain("back_to_back");
  endtask

  initial begin
    test_reset;
    test_valid_frame;
    test_min_frame;
    test_options;
    test_bad_checksum;
    test_rejects;
    test_eth_err;
    test_truncated;
    test_header_eof;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
